// File: rtl/darkpc_pkg.sv
// rtl/darkpc_pkg.sv - shared types and helpers for the multi-thread PC unit
package darkpc_pkg;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} pc_state_t;

  localparam int unsigned INSN_STEP = 4;

  // Clear the low 'align' bits of a redirect target; callers cast to XLEN.
  function automatic logic [63:0] align_pc(input logic [63:0] addr, input int unsigned align);
    align_pc = addr & ~((64'd1 << align) - 64'd1);
  endfunction

endpackage

// File: rtl/darkpc_flush.sv
// rtl/darkpc_flush.sv - boot/run/flush sequencer producing the fetch-valid qualifier
module darkpc_flush
  import darkpc_pkg::*;
#(
  parameter int FLUSH = 2
) (
  input  logic CLK,
  input  logic RES,
  input  logic EN,
  input  logic redir,
  output logic vld
);

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH);

  pc_state_t  state, state_nx;
  logic [2:0] cnt, cnt_nx;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    // BOOT leaves on the first edge whether or not EN is set
    if (state == BOOT) state_nx = RUN;
    if (EN) begin
      if (redir && (FLUSH_LD != 3'd0)) begin
        state_nx = darkpc_pkg::FLUSH;
        cnt_nx   = FLUSH_LD;
      end else if (state == darkpc_pkg::FLUSH) begin
        if (cnt <= 3'd1) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
    end
  end

  assign vld = (state == RUN);

endmodule

// File: rtl/darkpc_mt.sv
// rtl/darkpc_mt.sv - per-thread fetch PC, exception PC and active-thread select
module darkpc_mt
  import darkpc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              THREADS  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h0000_0080),
  parameter int              FLUSH    = 2,
  parameter int              ALIGN    = 2
) (
  input  logic                                          CLK,
  input  logic                                          RES,
  input  logic                                          EN,
  input  logic                                          TSW,
  input  logic                                          BR,
  input  logic [XLEN-1:0]                               BRPC,
  input  logic                                          TRAP,
  output logic [XLEN-1:0]                               PC,
  output logic [XLEN-1:0]                               NXPC,
  output logic [((THREADS > 1) ? $clog2(THREADS) : 1)-1:0] TID,
  output logic                                          VLD,
  output logic [XLEN-1:0]                               EPC
);

  localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

  logic [XLEN-1:0] pcs  [THREADS];
  logic [XLEN-1:0] epcs [THREADS];
  logic [TW-1:0]   tid;
  logic            run;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] pc_nx;

  darkpc_flush #(.FLUSH(FLUSH)) u_flush (
    .CLK   (CLK),
    .RES   (RES),
    .EN    (EN),
    .redir (BR | TRAP),
    .vld   (run)
  );

  assign br_target = XLEN'(align_pc(64'(BRPC), ALIGN));
  assign PC        = pcs[tid];
  assign EPC       = epcs[tid];
  assign NXPC      = PC + XLEN'(INSN_STEP);
  assign TID       = tid;
  assign VLD       = run;

  always_comb begin
    pc_nx = PC;
    if (TRAP)     pc_nx = TRAP_PC;
    else if (BR)  pc_nx = br_target;
    else if (run) pc_nx = NXPC;
  end

  // Only the active thread is written; a switch selects the next thread after its update.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      for (int t = 0; t < THREADS; t++) begin
        pcs[t]  <= RESET_PC;
        epcs[t] <= '0;
      end
      tid <= '0;
    end else if (EN) begin
      pcs[tid] <= pc_nx;
      if (TRAP) epcs[tid] <= PC;
      if (TSW && (THREADS > 1)) tid <= tid + TW'(1);
    end
  end

endmodule

// File: doc/darkpc_mt.md
# darkpc_mt

Multi-thread program-counter unit for the fetch stage of the darkriscv core. It generalises the single enabled PC register to THREADS independent PCs with a selectable active thread. It also adds redirect (branch/jump), trap entry with per-thread exception PC capture, and a post-redirect bubble counter that qualifies fetches with VLD. It sits between the decode/branch logic (redirect sources) and the instruction memory address port.

## Interface
- XLEN, 32, PC width
- THREADS, 2, number of hardware threads; power of two, 1..8
- RESET_PC, 0, reset value of every thread PC
- TRAP_PC, 32'h0000_0080, trap vector loaded on TRAP
- FLUSH, 2, invalid-fetch cycles after a redirect or trap; 0..7
- ALIGN, 2, number of PC LSBs forced to zero on redirect

Ports:
- CLK  in  1  clock, rising edge
- RES  in  1  reset, asynchronous, active-low
- EN  in  1  advance enable; 0 freezes all state
- TSW  in  1  thread switch request
- BR  in  1  redirect current thread
- BRPC  in  XLEN  redirect target
- TRAP  in  1  trap current thread
- PC  out  XLEN  fetch PC of active thread
- NXPC  out  XLEN  PC + 4, modulo 2^XLEN
- TID  out  max(1,$clog2(THREADS))  active thread index
- VLD  out  1  PC is a valid fetch address this cycle
- EPC  out  XLEN  exception PC of active thread

## Operation
- Reset (RES=0, asynchronous):
  - all PC[t] = RESET_PC; all EPC[t] = 0.
  - TID = 0; flush count = 0; state = BOOT; VLD = 0.
- States:
  - BOOT → RUN on the first rising edge after RES=1, independent of EN.
  - RUN → FLUSH on an EN edge with BR or TRAP when FLUSH>0.
  - FLUSH → RUN when the count reaches 0.
- VLD = 1 only in RUN.
- On an EN edge, the active thread's next PC is chosen by priority:
  - TRAP: PC = TRAP_PC and EPC[TID] = current PC.
  - else BR: PC = BRPC with the low ALIGN bits cleared.
  - else RUN: PC = NXPC.
  - else (BOOT/FLUSH): PC holds.
- Flush counter:
  - Loaded with FLUSH on TRAP/BR.
  - Decremented on each EN edge in FLUSH, exits at 0.
  - A BR/TRAP arriving during FLUSH reloads the counter.
- TSW on an EN edge:
  - The active thread's PC update above is applied first.
  - Then TID = (TID+1) mod THREADS; the new thread's stored PC appears next cycle.
  - The switch adds no bubble, but any pending flush count is kept.
  - THREADS=1: TSW ignored.
- EN=0 freezes PCs, EPCs, TID, state and count. Outputs remain stable.
- Inactive threads' PCs never change except through reset.
- Arithmetic is unsigned, XLEN bits, wrap-around: 0xFFFF_FFFC+4 = 0.

## Timing
- PC, TID, VLD and EPC are registered. NXPC is combinational from PC.
- Redirect/trap at edge n:
  - PC = target from cycle n+1.
  - VLD = 0 for cycles n+1..n+FLUSH.
  - VLD = 1 at n+FLUSH+1 with PC still equal to the target.
  - PC advances on the next EN edge.
- FLUSH=0: the redirect target is valid at n+1 and the FLUSH state is never entered.
- Async reset mid-operation forces reset values immediately, without waiting for a clock edge.
- Reset deassertion is assumed synchronised externally.

## Structure
- Package darkpc_pkg holds:
  - typedef enum {BOOT, RUN, FLUSH} pc_state_t
  - the opcode/alignment constant for the 4-byte instruction step
  - function align_pc(addr, ALIGN)
- Sub-module darkpc_flush: the state machine plus the 3-bit flush counter, producing VLD. Inputs are EN, BR|TRAP and the FLUSH parameter.
- The top level holds the PC and EPC arrays (unpacked [THREADS]) and the TID register.

## Test plan
- Reset/boot: hold RES=0 → PC=0, VLD=0, TID=0. Release with EN=1 → VLD=1 one edge later; PC then steps 0, 4, 8.
- Branch, FLUSH=2: at PC=0x10, BR with BRPC=0x103 → PC=0x100; VLD is 0,0,1; then PC=0x104. A second BR during a bubble reloads the count to 2.
- Trap beats branch: at PC=0x20, TRAP=BR=1 with BRPC=0x40 → PC=0x80, EPC=0x20, VLD low for 2 cycles.
- Thread switch, THREADS=2: thread0 at 0x8 with TSW → TID=1, PC=0, thread0 stored as 0xC. TSW again → TID=0, PC=0xC. EPC follows TID.
- Stall: EN=0 for 3 cycles mid-flush → PC, VLD and count are frozen. Flush resumes and completes after EN=1.
- Wrap and async reset: PC at 0xFFFF_FFFC steps to 0. Asserting RES=0 between clock edges mid-flush → PC=RESET_PC and VLD=0 immediately.
